// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external combinational full adder LSB-first over WIDTH cycles.
// Latency WIDTH+1 cycles from accepted start to the done pulse; start is only honoured in IDLE, never queued.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d   = a;
               b_sr_d   = b;
               carry_d  = cin;
               cnt_d    = '0;
               sum_sr_d = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // The final bit's adder output lands straight in the result register.
            if (cnt_q == LAST) begin
               sum_d   = {fa_sum, sum_sr_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Gated by state so a leftover carry never leaks to the adder outside RUN.
   assign fa_a   = (state_q == RUN) & a_sr_q[0];
   assign fa_b   = (state_q == RUN) & b_sr_q[0];
   assign fa_cin = (state_q == RUN) & carry_q;

   assign busy = busy_q;
   assign done = done_q;
   assign Sum  = sum_q;
   assign Cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition sequencer that drives a single external 1-bit full adder across WIDTH clock cycles to produce a WIDTH-bit sum with carry-out. The block sits between a requester, which uses a start/done handshake, and one Full_Adder instance. It holds the operand shift registers, the carry flip-flop and the result register, so one adder cell serves any operand width.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- Sum  output  WIDTH  registered result; holds until the next completion.
- Cout  output  1  registered carry-out; holds until the next completion.
- fa_a  output  1  bit driven to the adder's `a` input.
- fa_b  output  1  bit driven to the adder's `b` input.
- fa_cin  output  1  bit driven to the adder's `cin` input.
- fa_sum  input  1  adder's `Sum` output.
- fa_cout  input  1  adder's `Cout` output.

## Operation
- Internal state: a_sr, b_sr, sum_sr (each WIDTH bits), carry_q (1 bit), cnt ($clog2(WIDTH) bits), and a 3-state FSM: IDLE, RUN, DONE.
- IDLE:
  - On start=1: a_sr←a, b_sr←b, carry_q←cin, cnt←0, sum_sr←0, then go to RUN.
  - When start=0, no state changes.
- RUN:
  - Combinational drive: fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry_q.
  - Every cycle: sum_sr←{fa_sum, sum_sr[WIDTH-1:1]}; carry_q←fa_cout; a_sr and b_sr shift right by 1, filling with 0; cnt←cnt+1.
  - When cnt==WIDTH-1, that cycle is the final bit. At the same edge: Sum←{fa_sum, sum_sr[WIDTH-1:1]}, Cout←fa_cout, then go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- fa_a, fa_b and fa_cin are 0 whenever the FSM is not in RUN.
- start is ignored in RUN and DONE; it is neither queued nor latched. Operand inputs may change freely after acceptance.
- The result is the full WIDTH+1-bit sum: {Cout, Sum} = a + b + cin, with no overflow truncation beyond Cout.
- The external adder is purely combinational. This block assumes fa_sum and fa_cout settle within the same cycle.

## Timing
- Reset (asynchronous, any state):
  - FSM→IDLE.
  - busy=0, done=0, Sum=0, Cout=0, fa_a=fa_b=fa_cin=0.
  - All shift registers, carry_q and cnt are cleared.
- Reset during RUN aborts the operation: no done pulse, and Sum/Cout read 0.
- Latency: start sampled at edge 0 → RUN occupies cycles 1..WIDTH → done high in cycle WIDTH+1 (9 cycles for WIDTH=8).
- Sum and Cout change only at the edge entering DONE. Both are valid and stable in the done cycle and remain so until the next completion or reset.
- busy rises the cycle after start is accepted and falls the cycle after done.
- Throughput: one add per WIDTH+2 cycles. The earliest next accepted start is the cycle after done, when the FSM is in IDLE.
- start=1 held continuously: a new operation is accepted in every IDLE cycle, giving back-to-back operations with a one-cycle IDLE gap.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start for 1 cycle → done in cycle 9; Sum=0x96, Cout=0. fa_a sequence in cycles 1..8 is 0,1,0,1,1,0,1,0.
- a=0xFF, b=0x01, cin=0 → Sum=0x00, Cout=1. Then a=0xFF, b=0xFF, cin=1 → Sum=0xFF, Cout=1 (full carry ripple).
- start pulsed at cycles 3 and 9 (DONE) of a running add, with different operands → both ignored. The first result is unchanged, and exactly one done pulse occurs.
- start held high for 30 cycles with a=0x01, b=0x01, cin=0 → done in cycles 9, 19 and 29. Each done shows Sum=0x02, Cout=0, with IDLE in cycles 10 and 20.
- Prior result Sum=0x96; assert rst asynchronously mid-cycle during RUN cycle 4 → busy, done, Sum, Cout and fa_* are 0 immediately, with no done pulse. The next start completes correctly.
- WIDTH=2, a=2'b11, b=2'b01, cin=1 → done in cycle 3; Sum=2'b01, Cout=1.
